// File: rtl/decoder_scan_reg.sv
// rtl/decoder_scan_reg.sv - registered one-hot decoder with direct select and round-robin scan modes
// Optional build macro DECODER_ACTIVE_LOW_EN makes out_o active-low (selected bit 0, idle all ones).
module decoder_scan_reg #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DIV     = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               mode_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [NUM_OUT-1:0] out_o,
  output logic [SEL_W-1:0]   idx_o,
  output logic               oor_o,
  output logic               wrap_o
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  // One extra bit so NUM_OUT == 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0]   NUM_OUT_X = (SEL_W + 1)'(NUM_OUT);
  localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(NUM_OUT - 1);
  localparam logic [PW-1:0]    PRE_LAST  = PW'(DIV - 1);

`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic [NUM_OUT-1:0] OUT_IDLE = '1;
`else
  localparam logic [NUM_OUT-1:0] OUT_IDLE = '0;
`endif

  logic [PW-1:0]    pre_q;
  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] idx_scan_nxt;
  logic [PW-1:0]    pre_scan_nxt;
  logic             pre_done;
  logic             idx_at_last;
  logic             sel_valid;

  function automatic logic [NUM_OUT-1:0] decode(input logic [SEL_W-1:0] idx);
    logic [NUM_OUT-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      v[i] = (idx == SEL_W'(i));
    end
`ifdef DECODER_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  assign sel_valid   = ({1'b0, sel_i} < NUM_OUT_X);
  assign pre_done    = (pre_q == PRE_LAST);
  assign idx_at_last = (idx_q == IDX_LAST);

  always_comb begin
    pre_scan_nxt = pre_q + PW'(1);
    idx_scan_nxt = idx_q;
    if (pre_done) begin
      pre_scan_nxt = '0;
      idx_scan_nxt = idx_at_last ? '0 : idx_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_o  <= OUT_IDLE;
      idx_q  <= '0;
      pre_q  <= '0;
      oor_o  <= 1'b0;
      wrap_o <= 1'b0;
    end else if (!enable_i) begin
      // Paused: index and prescaler hold so scanning resumes without a skip.
      out_o  <= OUT_IDLE;
      oor_o  <= 1'b0;
      wrap_o <= 1'b0;
    end else if (!mode_i) begin
      pre_q  <= '0;
      wrap_o <= 1'b0;
      if (sel_valid) begin
        idx_q <= sel_i;
        out_o <= decode(sel_i);
        oor_o <= 1'b0;
      end else begin
        out_o <= OUT_IDLE;
        oor_o <= 1'b1;
      end
    end else begin
      pre_q  <= pre_scan_nxt;
      idx_q  <= idx_scan_nxt;
      out_o  <= decode(idx_scan_nxt);
      oor_o  <= 1'b0;
      wrap_o <= pre_done && idx_at_last;
    end
  end

  assign idx_o = idx_q;

endmodule

// File: tb/tb_decoder_scan_reg.sv
// tb/tb_decoder_scan_reg.sv - randomized bench for decoder_scan_reg across three parameter sets
// Honours DECODER_ACTIVE_LOW_EN when computing expected out_o values.
module tb_decoder_scan_reg;

  logic       clk = 1'b0;
  logic       rst, en, mode;
  logic [2:0] sel;

  logic [7:0] out_a; logic [2:0] idx_a; logic oor_a, wrap_a;
  logic [5:0] out_b; logic [2:0] idx_b; logic oor_b, wrap_b;
  logic [2:0] out_c; logic [1:0] idx_c; logic oor_c, wrap_c;

  int errors = 0;
  int checks = 0;

  localparam int NK = 3;
  int n_of   [NK] = '{8, 6, 3};
  int div_of [NK] = '{4, 2, 1};
  int selm_of[NK] = '{7, 7, 3};

  int m_idx[NK], m_pre[NK], e_out[NK], e_oor[NK], e_wrap[NK];

  decoder_scan_reg #(.SEL_W(3), .NUM_OUT(8), .DIV(4)) dut_a (
    .clk_i(clk), .reset_i(rst), .enable_i(en), .mode_i(mode), .sel_i(sel),
    .out_o(out_a), .idx_o(idx_a), .oor_o(oor_a), .wrap_o(wrap_a));

  decoder_scan_reg #(.SEL_W(3), .NUM_OUT(6), .DIV(2)) dut_b (
    .clk_i(clk), .reset_i(rst), .enable_i(en), .mode_i(mode), .sel_i(sel),
    .out_o(out_b), .idx_o(idx_b), .oor_o(oor_b), .wrap_o(wrap_b));

  decoder_scan_reg #(.SEL_W(2), .NUM_OUT(3), .DIV(1)) dut_c (
    .clk_i(clk), .reset_i(rst), .enable_i(en), .mode_i(mode), .sel_i(sel[1:0]),
    .out_o(out_c), .idx_o(idx_c), .oor_o(oor_c), .wrap_o(wrap_c));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pol(input int v, input int n);
`ifdef DECODER_ACTIVE_LOW_EN
    return ((1 << n) - 1) & ~v;
`else
    return v;
`endif
  endfunction

  // Reference: index counts positions 0..n-1, dwell counts clocks spent on the current index.
  function automatic void model_edge(input int k);
    int s;
    s = sel & selm_of[k];
    if (rst) begin
      m_idx[k] = 0; m_pre[k] = 0;
      e_out[k] = pol(0, n_of[k]); e_oor[k] = 0; e_wrap[k] = 0;
    end else if (!en) begin
      e_out[k] = pol(0, n_of[k]); e_oor[k] = 0; e_wrap[k] = 0;
    end else if (!mode) begin
      m_pre[k] = 0; e_wrap[k] = 0;
      if (s < n_of[k]) begin
        m_idx[k] = s; e_out[k] = pol(1 << s, n_of[k]); e_oor[k] = 0;
      end else begin
        e_out[k] = pol(0, n_of[k]); e_oor[k] = 1;
      end
    end else begin
      e_oor[k] = 0;
      m_pre[k] = m_pre[k] + 1;
      e_wrap[k] = 0;
      if (m_pre[k] == div_of[k]) begin
        m_pre[k] = 0;
        m_idx[k] = (m_idx[k] + 1) % n_of[k];
        e_wrap[k] = (m_idx[k] == 0);
      end
      e_out[k] = pol(1 << m_idx[k], n_of[k]);
    end
  endfunction

  task automatic apply(input logic r, input logic e, input logic m, input logic [2:0] s);
    @(negedge clk);
    rst = r; en = e; mode = m; sel = s;
    @(posedge clk);
    for (int k = 0; k < NK; k++) model_edge(k);
    #1;
    check("a_out",  32'(out_a),  e_out[0]);
    check("a_idx",  32'(idx_a),  m_idx[0]);
    check("a_oor",  32'(oor_a),  e_oor[0]);
    check("a_wrap", 32'(wrap_a), e_wrap[0]);
    check("b_out",  32'(out_b),  e_out[1]);
    check("b_idx",  32'(idx_b),  m_idx[1]);
    check("b_oor",  32'(oor_b),  e_oor[1]);
    check("b_wrap", 32'(wrap_b), e_wrap[1]);
    check("c_out",  32'(out_c),  e_out[2]);
    check("c_idx",  32'(idx_c),  m_idx[2]);
    check("c_oor",  32'(oor_c),  e_oor[2]);
    check("c_wrap", 32'(wrap_c), e_wrap[2]);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 3'd0;
    apply(1, 0, 0, 0);
    apply(1, 1, 1, 3);
    check("rst_out_a", 32'(out_a), pol(0, 8));
    check("rst_idx_a", 32'(idx_a), 0);

    apply(0, 1, 0, 5);
    check("sel5_out_a", 32'(out_a), pol(8'h20, 8));
    check("sel5_idx_a", 32'(idx_a), 5);
    apply(0, 0, 0, 5);
    check("dis_out_a", 32'(out_a), pol(0, 8));
    check("dis_idx_a", 32'(idx_a), 5);

    apply(0, 1, 0, 3);
    check("sel3_out_a", 32'(out_a), pol(8'h08, 8));
    apply(0, 1, 0, 6);
    check("sel6_oor_b", 32'(oor_b), 1);
    check("sel6_idx_b", 32'(idx_b), 3);
    apply(0, 1, 0, 7);
    check("sel7_out_b", 32'(out_b), pol(0, 6));
    apply(0, 1, 0, 2);
    check("sel2_out_b", 32'(out_b), pol(6'b000100, 6));

    apply(1, 0, 0, 0);
    for (int i = 1; i <= 34; i++) begin
      apply(0, 1, 1, 0);
      if (i == 3)  check("scan3_out_a",  32'(out_a), pol(8'h01, 8));
      if (i == 4)  check("scan4_out_a",  32'(out_a), pol(8'h02, 8));
      if (i == 31) check("scan31_wrap",  32'(wrap_a), 0);
      if (i == 32) check("scan32_wrap",  32'(wrap_a), 1);
      if (i == 32) check("scan32_out_a", 32'(out_a), pol(8'h01, 8));
      if (i == 33) check("scan33_wrap",  32'(wrap_a), 0);
    end

    apply(1, 0, 0, 0);
    apply(0, 1, 1, 0);
    apply(0, 1, 1, 0);
    for (int i = 0; i < 5; i++) apply(0, 0, 1, 0);
    check("pause_out_a", 32'(out_a), pol(0, 8));
    apply(0, 1, 1, 0);
    check("resume1_idx_a", 32'(idx_a), 0);
    apply(0, 1, 1, 0);
    check("resume2_idx_a", 32'(idx_a), 1);
    apply(0, 1, 1, 0);
    apply(1, 1, 1, 0);
    check("midrst_idx_a", 32'(idx_a), 0);
    check("midrst_out_a", 32'(out_a), pol(0, 8));

    for (int i = 0; i < 3000; i++) begin
      logic r, e, m;
      r = ($urandom_range(0, 99) < 2);
      e = ($urandom_range(0, 99) < 85);
      m = (($urandom_range(0, 99) < 8) ? ~mode : mode);
      apply(r, e, m, 3'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_scan_reg.md
Name: decoder_scan_reg

Overview:
Parametrised, registered successor to the fixed 3-to-8 decoder: SEL_W-bit select to NUM_OUT one-hot outputs, with an enable.
- Direct mode: decodes sel_i.
- Scan mode: steps an internal index through all outputs, holding each for DIV clocks. Intended for display digit/anode multiplexing and round-robin strobes.
- All outputs are registered; one clock domain.

Parameters:
SEL_W, 3, select/index width in bits (>=1)
NUM_OUT, 8, number of one-hot outputs; 2 <= NUM_OUT <= 2**SEL_W
DIV, 4, scan dwell in clocks per index (>=1); prescaler width = max(1, $clog2(DIV))

Ports:
clk_i  input  1  clock, rising edge
reset_i  input  1  synchronous, active-high reset
enable_i  input  1  1 = decode/scan active; 0 = outputs off, state held
mode_i  input  1  0 = direct decode of sel_i; 1 = auto scan
sel_i  input  SEL_W  select in direct mode
out_o  output  NUM_OUT  registered one-hot output
idx_o  output  SEL_W  registered current index
oor_o  output  1  registered: sel_i >= NUM_OUT in direct mode
wrap_o  output  1  one-cycle pulse when scan index wraps NUM_OUT-1 -> 0

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (reset_i=1 at an edge): out_o=0, idx_o=0, oor_o=0, wrap_o=0, prescaler=0. Reset has priority over every other input, including mid-scan.
- Latency: 1 clock. Every output reflects the inputs sampled at the previous rising edge.
- enable_i=0 at an edge:
  - out_o=0, wrap_o=0, oor_o=0.
  - idx_o and prescaler hold.
  - mode_i and sel_i are ignored.
- Direct mode (enable_i=1, mode_i=0):
  - prescaler <= 0; wrap_o <= 0.
  - If sel_i < NUM_OUT: idx_o <= sel_i; out_o <= one-hot(sel_i); oor_o <= 0.
  - Else: idx_o holds; out_o <= 0; oor_o <= 1.
- Scan mode (enable_i=1, mode_i=1), per edge; oor_o <= 0:
  - If prescaler == DIV-1:
    - prescaler <= 0.
    - idx_o <= (idx_o == NUM_OUT-1) ? 0 : idx_o+1.
    - wrap_o <= (idx_o == NUM_OUT-1).
  - Else: prescaler <= prescaler+1; idx_o holds; wrap_o <= 0.
  - out_o <= one-hot(next idx_o), so out_o and idx_o always agree in the same cycle.
  - DIV=1: the index advances on every edge.
- Mode transitions:
  - Direct -> scan: scanning resumes from the last valid direct index with prescaler=0.
  - Scan -> direct: takes effect on the next edge; prescaler is cleared.
- Enable low during scan pauses it. On re-enable, the prescaler continues from its held value and there is no skip.
- Invariants:
  - out_o has at most one bit set.
  - out_o bits at or above NUM_OUT never exist (width is NUM_OUT).
  - idx_o never reaches NUM_OUT.
- Arithmetic:
  - Index increment and compare are SEL_W bits, with explicit wrap at NUM_OUT-1, not at 2**SEL_W-1.
  - Prescaler compare is against DIV-1 at prescaler width.

Optional Feature:
Macro DECODER_ACTIVE_LOW_EN.
- Defined: out_o is active-low. Reset and disabled value is all ones; the selected bit is 0 and all others are 1. Out-of-range direct select gives all ones.
- Not defined: active-high as above.
- idx_o, oor_o and wrap_o are unaffected either way.

Test Plan:
- Reset, then enable_i=1, mode_i=0, sel_i=5 (defaults) -> one clock later out_o=8'b0010_0000, idx_o=5, oor_o=0. Then enable_i=0 -> out_o=0, idx_o=5.
- NUM_OUT=6, SEL_W=3, direct, sel_i=6 then 7 -> out_o=0, oor_o=1, idx_o holds its prior value. Then sel_i=2 -> out_o=6'b000100, oor_o=0.
- Defaults, scan from reset, DIV=4:
  - out_o=8'h01 after edges 1-3; 8'h02 after edge 4.
  - Each later index holds for 4 clocks.
  - After edge 32, out_o=8'h01 with wrap_o=1 for exactly one cycle.
- DIV=1, NUM_OUT=3, scan -> out_o cycles 001,010,100,001 on consecutive clocks; wrap_o high every third cycle.
- Scan paused mid-dwell (enable_i=0 for 5 clocks at prescaler=2), then resumed -> index advances exactly 2 edges after re-enable; out_o=0 throughout the pause. Assert reset_i mid-scan -> next cycle all outputs 0.
- Build with DECODER_ACTIVE_LOW_EN, direct, sel_i=3 -> out_o=8'b1111_0111; reset and disable -> 8'hFF.
